hs_pipe_buf: RTL and testbench
==============================

# hs_pipe_buf

Parametrised valid/ready stream buffer between a producer (tx-class block) and a consumer (rx-class block). It replaces ad-hoc registered-valid delay stages: it carries data and valid through DEPTH entries of storage and registers the ready path, so neither side sees a combinational path from the other. It reports fill level and an almost-full flag for upstream throttling.

## Interface
- DATA_W, 32: payload width in bits.
- DEPTH, 4: storage entries; power of two, ≥2.
- AFULL_TH, 3: level at or above which afull asserts; 1..DEPTH.
- LVL_W, $clog2(DEPTH+1): width of level (derived, not overridden).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  upstream payload.
- s_valid  in  1  upstream word present.
- s_ready  out  1  buffer can accept; registered.
- m_data  out  DATA_W  downstream payload at head of buffer.
- m_valid  out  1  head entry valid; registered.
- m_ready  in  1  downstream accepts.
- level  out  LVL_W  entries currently held, 0..DEPTH.
- afull  out  1  level ≥ AFULL_TH; registered.

## Operation
- Push on rising edge when s_valid && s_ready; pop when m_valid && m_ready.
- Storage: circular array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
- Count register cnt (LVL_W bits): cnt + push − pop each cycle; never exceeds DEPTH, never negative.
- s_ready = (cnt != DEPTH), from register state only; no dependence on m_ready in the same cycle.
- m_valid = (cnt != 0), from register state only; no dependence on s_valid in the same cycle.
- m_data = mem[rd_ptr]; stable while m_valid && !m_ready (producer-side hold rule mirrored downstream).
- Ordering strictly FIFO; no bypass, no drop, no reorder.
- Upstream protocol obligation: once s_valid is high, s_data/s_valid hold until accepted. Buffer does not check it.
- Reset (rst_n low, any time, including mid-transfer): ptrs 0, cnt 0, s_ready 1 after release is held at reset value 1? No: during reset s_ready = 0; first cycle after release s_ready = 1. m_valid 0, level 0, afull 0, m_data undefined-but-X-free (mem not reset; m_data gated to 0 when cnt==0).

## Timing
- Latency: word pushed on edge k is presented on m_valid/m_data during cycle after edge k (1 cycle); poppable at edge k+1.
- Throughput: 1 word/cycle sustained when 0 < cnt < DEPTH and both sides ready.
- Full (cnt==DEPTH) with pop at edge k: s_ready rises in cycle after k; push in the same edge is impossible (s_ready was 0).
- Empty (cnt==0) with s_valid: push only; m_valid rises next cycle; no same-cycle pass-through.
- Simultaneous push and pop with 0<cnt<DEPTH: cnt unchanged, both ptrs advance.
- level and afull reflect cnt after the edge; afull updates on same edge as cnt.
- rd_ptr/wr_ptr wrap from DEPTH−1 to 0 without gap.

## Structure
- Shared package hs_pkg: clog2 helper, default DATA_W, handshake-fire macro/function `fire(valid, ready)`.
- One natural sub-module: hs_buf_mem (DEPTH×DATA_W register array, one write port, one async read port). Counter/pointer control stays in hs_pipe_buf.
- Expected size ~150–250 RTL lines.

## Test plan
- Reset release, m_ready=1, push 0x11,0x22,0x33 back-to-back → m_data 0x11,0x22,0x33 on consecutive cycles starting one cycle after first push; level peaks at 1.
- DEPTH=4, m_ready=0, push 0xA0..0xA5 held → exactly 4 accepted, s_ready=0 after 4th, level=4, afull=1 from 3rd push; then m_ready=1 → 0xA0..0xA5 drained in order, no loss.
- Full, m_ready=1 and s_valid=1 same cycle → pop only that edge, s_ready=1 next cycle, level 4→3→3 steady.
- Random s_valid/m_ready at 50% each, 10 000 words, DATA_W=8, DEPTH=8 → scoreboard order match, cnt never >8, m_data stable while stalled.
- Assert rst_n low with level=3 mid-stream → level 0, m_valid 0, afull 0 immediately (async); after release first new word 0x5A emerges first.
- Wrap: DEPTH=2, 7 push/pop pairs of 0x01..0x07 → correct order across ptr wrap, level alternates 1/0.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared handshake helpers for valid/ready stream blocks.
package hs_pkg;

    localparam int unsigned DefDataW = 32;

    // Ceiling log2 that stays usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/hs_buf_mem.sv
// Register array storage for the stream buffer: one write port, one async read port.
module hs_buf_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Payload storage is intentionally not reset; readers gate it when empty.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_pipe_buf.sv
// Valid/ready stream buffer with registered ready/valid, fill level and almost-full flag.
module hs_pipe_buf
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AFULL_TH = 3,
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LVL_W-1:0]  level,
    output logic              afull
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  cnt_q, cnt_d;
    logic              s_ready_q, afull_q;
    logic              push, pop;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        push  = fire(s_valid, s_ready_q);
        pop   = fire(m_valid, m_ready);
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + LVL_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - LVL_W'(1);
        end
    end

    // s_ready is its own flop so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q     <= cnt_d;
            s_ready_q <= (cnt_d != LVL_W'(DEPTH));
            afull_q   <= (cnt_d >= LVL_W'(AFULL_TH));
        end
    end

    hs_buf_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (s_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign s_ready = s_ready_q;
    assign m_valid = (cnt_q != '0);
    assign m_data  = m_valid ? rd_data : '0;
    assign level   = cnt_q;
    assign afull   = afull_q;

endmodule

// File: tb/tb_hs_pipe_buf.sv
// Directed vector bench for hs_pipe_buf (DEPTH=4, AFULL_TH=3) with a scoreboarded random phase.
module tb_hs_pipe_buf;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [LW-1:0] level;
    logic          afull;

    int total = 0;
    int bad = 0;

    hs_pipe_buf #(
        .DATA_W   (DW),
        .DEPTH    (4),
        .AFULL_TH (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .level   (level),
        .afull   (afull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          ev;
        logic [DW-1:0] ed;
        logic          er;
        logic [LW-1:0] el;
        logic          ea;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic sv, input logic [DW-1:0] sd, input logic mr,
                                input logic ev, input logic [DW-1:0] ed, input logic er,
                                input logic [LW-1:0] el, input logic ea);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr;
        v.ev = ev; v.ed = ed; v.er = er; v.el = el; v.ea = ea;
        return v;
    endfunction

    logic [DW-1:0] q [$];
    logic [DW-1:0] next_word;
    logic          pre_push, pre_pop, pre_stall;
    logic [DW-1:0] pre_data;

    initial begin
        // back-to-back with m_ready=1, level peaks at 1
        vecs[0]  = mk(1, 32'h11, 1,  1, 32'h11, 1, 1, 0);
        vecs[1]  = mk(1, 32'h22, 1,  1, 32'h22, 1, 1, 0);
        vecs[2]  = mk(1, 32'h33, 1,  1, 32'h33, 1, 1, 0);
        vecs[3]  = mk(0, 32'h00, 1,  0, 32'h00, 1, 0, 0);
        // fill to full with consumer stalled
        vecs[4]  = mk(1, 32'hA0, 0,  1, 32'hA0, 1, 1, 0);
        vecs[5]  = mk(1, 32'hA1, 0,  1, 32'hA0, 1, 2, 0);
        vecs[6]  = mk(1, 32'hA2, 0,  1, 32'hA0, 1, 3, 1);
        vecs[7]  = mk(1, 32'hA3, 0,  1, 32'hA0, 0, 4, 1);
        vecs[8]  = mk(1, 32'hA4, 0,  1, 32'hA0, 0, 4, 1);
        // full + pop + s_valid: pop only, then steady push/pop at level 3
        vecs[9]  = mk(1, 32'hA4, 1,  1, 32'hA1, 1, 3, 1);
        vecs[10] = mk(1, 32'hA4, 1,  1, 32'hA2, 1, 3, 1);
        vecs[11] = mk(1, 32'hA5, 1,  1, 32'hA3, 1, 3, 1);
        vecs[12] = mk(0, 32'h00, 1,  1, 32'hA4, 1, 2, 0);
        vecs[13] = mk(0, 32'h00, 1,  1, 32'hA5, 1, 1, 0);
        vecs[14] = mk(0, 32'h00, 1,  0, 32'h00, 1, 0, 0);

        // reset state while held
        #3;
        chk("rst s_ready", 64'(s_ready), 64'd0);
        chk("rst m_valid", 64'(m_valid), 64'd0);
        chk("rst level",   64'(level),   64'd0);
        chk("rst afull",   64'(afull),   64'd0);
        chk("rst m_data",  64'(m_data),  64'd0);
        #19 rst_n = 1'b1;
        step();
        chk("post-rst s_ready", 64'(s_ready), 64'd1);

        for (int i = 0; i < 15; i++) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            step();
            chk($sformatf("vec%0d m_valid", i), 64'(m_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d m_data", i),  64'(m_data),  64'(vecs[i].ed));
            chk($sformatf("vec%0d s_ready", i), 64'(s_ready), 64'(vecs[i].er));
            chk($sformatf("vec%0d level", i),   64'(level),   64'(vecs[i].el));
            chk($sformatf("vec%0d afull", i),   64'(afull),   64'(vecs[i].ea));
        end

        // pointer wrap: alternate single push and single pop
        for (int i = 1; i <= 7; i++) begin
            s_valid = 1'b1; s_data = DW'(i); m_ready = 1'b0;
            step();
            chk($sformatf("wrap%0d data", i),  64'(m_data), 64'(i));
            chk($sformatf("wrap%0d level", i), 64'(level),  64'd1);
            s_valid = 1'b0; m_ready = 1'b1;
            step();
            chk($sformatf("wrap%0d empty", i), 64'(level),  64'd0);
        end

        // async reset with level 3
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 32'hC0 + DW'(i);
            step();
        end
        s_valid = 1'b0;
        chk("pre-arst level", 64'(level), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst level",   64'(level),   64'd0);
        chk("arst m_valid", 64'(m_valid), 64'd0);
        chk("arst afull",   64'(afull),   64'd0);
        chk("arst s_ready", 64'(s_ready), 64'd0);
        #10 rst_n = 1'b1;
        step();
        chk("arst rel s_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b1; s_data = 32'h5A;
        step();
        s_valid = 1'b0;
        chk("arst new data",  64'(m_data), 64'h5A);
        chk("arst new level", 64'(level),  64'd1);
        m_ready = 1'b1;
        step();
        chk("arst drained", 64'(m_valid), 64'd0);

        // random traffic against a queue model
        next_word = 32'h1000;
        for (int i = 0; i < 1200; i++) begin
            if (!s_valid && $urandom_range(1) == 1) begin
                s_valid = 1'b1;
                s_data  = next_word;
                next_word++;
            end
            m_ready   = 1'($urandom_range(1));
            pre_push  = s_valid && s_ready;
            pre_pop   = m_valid && m_ready;
            pre_stall = m_valid && !m_ready;
            pre_data  = m_data;
            step();
            if (pre_pop) void'(q.pop_front());
            if (pre_push) begin
                q.push_back(s_data);
                s_valid = 1'b0;
            end
            chk("rnd level",   64'(level),   64'(q.size()));
            chk("rnd s_ready", 64'(s_ready), 64'(q.size() != 4));
            chk("rnd afull",   64'(afull),   64'(q.size() >= 3));
            if (q.size() > 0) chk("rnd order", 64'(m_data), 64'(q[0]));
            if (pre_stall) chk("rnd hold", 64'(m_data), 64'(pre_data));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
